// File: rtl/onehot_rr_arbiter_pkg.sv
// onehot_rr_arbiter_pkg: shared state encoding and width helper for the round-robin arbiter
package onehot_rr_arbiter_pkg;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/onehot_priority_rotate.sv
// onehot_priority_rotate: one-hot first requester searching upward from last+1 with wrap
module onehot_priority_rotate #(
  parameter int N_REQ = 4,
  parameter int W_IDX = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [W_IDX-1:0] last_i,
  output logic [N_REQ-1:0] win_o
);
  logic [N_REQ-1:0]   hi_mask;
  logic [2*N_REQ-1:0] dbl, first;
  // lower copy keeps only bits above last; the upper copy supplies the wrapped search
  always_comb begin
    for (int i = 0; i < N_REQ; i++) hi_mask[i] = i > int'(last_i);
    dbl   = {req_i, req_i & hi_mask};
    first = dbl & (~dbl + 1'b1);
    win_o = first[N_REQ-1:0] | first[2*N_REQ-1:N_REQ];
  end
endmodule

// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter: locking round-robin arbiter with registered one-hot grant
module onehot_rr_arbiter
  import onehot_rr_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W_IDX = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic             release_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             grant_valid_o,
  output logic [W_IDX-1:0] grant_idx_o
);
  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d, cand, win;
  logic [W_IDX-1:0] last_q, last_d, idx_q, idx_d;
  logic             valid_q, go;
  // the releasing owner never competes in the arbitration that replaces it
  assign cand = state_q == LOCKED ? req_i & ~grant_q : req_i;
  onehot_priority_rotate #(.N_REQ(N_REQ), .W_IDX(W_IDX)) u_rot (
    .req_i (cand),
    .last_i(last_q),
    .win_o (win)
  );
  // arbitrate on any request while idle, or on release while locked; otherwise hold
  always_comb begin
    go      = state_q == IDLE ? |req_i : release_i;
    grant_d = go ? win : grant_q;
    state_d = |grant_d ? LOCKED : IDLE;
    idx_d   = '0;
    for (int i = 0; i < N_REQ; i++) if (grant_d[i]) idx_d = idx_d | W_IDX'(i);
    last_d  = go && |win ? idx_d : last_q;
  end
  // state, priority pointer and registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      last_q  <= W_IDX'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= |grant_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  assign grant_o       = grant_q;
  assign grant_valid_o = valid_q;
  assign grant_idx_o   = idx_q;
  assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// tb_onehot_rr_arbiter: directed and model-checked random test of the round-robin arbiter
module tb_onehot_rr_arbiter;
  logic       clk = 1'b0, rst = 1'b1, rel = 1'b0;
  logic [3:0] req = '0, grant;
  logic       gv;
  logic [1:0] gidx;
  int         total = 0, bad = 0;
  logic [3:0] m_grant, nw;
  logic [1:0] m_last, m_idx, k;
  logic       m_locked;

  onehot_rr_arbiter #(.N_REQ(4), .W_IDX(2)) dut (
    .clk(clk), .rst(rst), .req_i(req), .release_i(rel),
    .grant_o(grant), .grant_valid_o(gv), .grant_idx_o(gidx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] ei);
    total++;
    assert ({grant, gv, gidx} === {eg, |eg, ei}) else begin
      bad++;
      $error("FAIL %s: got grant=%b valid=%b idx=%0d, want grant=%b valid=%b idx=%0d",
             tag, grant, gv, gidx, eg, |eg, ei);
    end
  endtask

  initial begin
    tick(); tick();
    chk("reset", 4'b0000, 2'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); chk("idle_no_req", 4'b0000, 2'd0); end
    req = 4'b1010;
    tick(); chk("first_grant", 4'b0010, 2'd1);
    rel = 1'b1; tick(); rel = 1'b0; chk("switch_to_3", 4'b1000, 2'd3);
    tick(); chk("frozen", 4'b1000, 2'd3);
    rel = 1'b1; tick(); rel = 1'b0; chk("wrap_to_1", 4'b0010, 2'd1);
    req = 4'b0000; rel = 1'b1; tick(); rel = 1'b0; chk("release_to_idle", 4'b0000, 2'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111;
    tick(); chk("rot_0", 4'b0001, 2'd0);
    rel = 1'b1;
    tick(); chk("rot_1", 4'b0010, 2'd1);
    tick(); chk("rot_2", 4'b0100, 2'd2);
    tick(); chk("rot_3", 4'b1000, 2'd3);
    tick(); chk("rot_wrap", 4'b0001, 2'd0);
    req = 4'b0100; tick(); rel = 1'b0; chk("owner2", 4'b0100, 2'd2);
    req = 4'b0000;
    for (int i = 0; i < 10; i++) begin tick(); chk("owner_drop_hold", 4'b0100, 2'd2); end
    rel = 1'b1; tick(); rel = 1'b0; chk("owner2_release", 4'b0000, 2'd0);
    rel = 1'b1; tick(); rel = 1'b0; chk("release_idle_ignored", 4'b0000, 2'd0);
    req = 4'b0011; tick(); chk("after_last2", 4'b0001, 2'd0);
    req = 4'b0001; rel = 1'b1; tick(); rel = 1'b0; chk("owner_excluded", 4'b0000, 2'd0);
    tick(); chk("sole_wraps_back", 4'b0001, 2'd0);
    req = 4'b0000; rel = 1'b1; tick(); rel = 1'b0; chk("idle_again", 4'b0000, 2'd0);
    req = 4'b0101; tick(); chk("pre_reset_owner", 4'b0100, 2'd2);
    rst = 1'b1; #1; chk("async_reset", 4'b0000, 2'd0);
    tick(); rst = 1'b0;
    tick(); chk("pointer_reset", 4'b0001, 2'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    m_grant = '0; m_last = 2'd3; m_idx = '0; m_locked = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      req = 4'($urandom_range(0, 15));
      rel = ($urandom_range(0, 2) == 0);
      if (m_locked ? rel : |req) begin
        nw = '0;
        for (int j = 1; j <= 4; j++) begin
          k = 2'(m_last + 2'(j));
          if (nw == 4'b0000 && req[k] && !(m_locked && m_grant[k])) begin
            nw = 4'b0001 << k;
            m_idx = k;
          end
        end
        m_grant = nw;
        m_locked = |nw;
        if (|nw) m_last = m_idx;
        else m_idx = 2'd0;
      end
      tick();
      chk("random", m_grant, m_idx);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
